// File: rtl/audio_i2s_out_if.sv
// Sample handshake bundle between the playback logic (master) and the I2S output stage (slave).
// Each channel carries its own valid/ready pair.
interface audio_i2s_out_if;
  logic [15:0] sample_data_l;
  logic        sample_valid_l;
  logic [15:0] sample_data_r;
  logic        sample_valid_r;
  logic        left_chan_ready;
  logic        right_chan_ready;

  modport master (
    output sample_data_l, sample_valid_l, sample_data_r, sample_valid_r,
    input  left_chan_ready, right_chan_ready
  );

  modport slave (
    input  sample_data_l, sample_valid_l, sample_data_r, sample_valid_r,
    output left_chan_ready, right_chan_ready
  );
endinterface

// File: rtl/audio_i2s_out.sv
// Stereo I2S serialiser: one FIFO per channel, a BCLK divider from clk, and a 32-bit frame
// shifter that pops both FIFOs together at frame start or repeats the last frame on underrun.
module audio_i2s_out #(
  parameter int DEPTH    = 8,
  parameter int HALF_DIV = 16
) (
  input  logic           clk,
  input  logic           reset,
  audio_i2s_out_if.slave smp,
  output logic           AUD_BCLK,
  output logic           AUD_DACLRCK,
  output logic           AUD_DACDAT,
  output logic           underrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [15:0]   mem_r [2][DEPTH];
  logic [AW-1:0] wr_r  [2];
  logic [AW-1:0] rd_r  [2];
  logic [CW-1:0] cnt_r [2];

  logic [DW-1:0] div_r;
  logic          bclk_r;
  logic [4:0]    bit_cnt_r;
  logic [31:0]   sh_r;
  logic [31:0]   last_r;
  logic          dat_r;
  logic          lrck_r;
  logic          und_r;

  logic [15:0]   data_s  [2];
  logic          valid_s [2];
  logic          ready_s [2];
  logic          push_s  [2];
  logic          wrap_s;
  logic          fall_s;
  logic          start_s;
  logic          both_s;
  logic          pop_s;
  logic [4:0]    next_bit_s;
  logic [31:0]   frame_s;

  // Handshake decode, edge detection and frame-start pop decision.
  always_comb begin
    data_s[0]  = smp.sample_data_l;
    data_s[1]  = smp.sample_data_r;
    valid_s[0] = smp.sample_valid_l;
    valid_s[1] = smp.sample_valid_r;
    for (int ch = 0; ch < 2; ch++) begin
      ready_s[ch] = (cnt_r[ch] != CW'(DEPTH));
      push_s[ch]  = valid_s[ch] && ready_s[ch];
    end
    wrap_s     = (div_r == DW'(HALF_DIV - 1));
    fall_s     = wrap_s && bclk_r;
    start_s    = fall_s && (bit_cnt_r == 5'd31);
    both_s     = (cnt_r[0] != {CW{1'b0}}) && (cnt_r[1] != {CW{1'b0}});
    pop_s      = start_s && both_s;
    next_bit_s = bit_cnt_r + 5'd1;
    if (pop_s) begin
      frame_s = {mem_r[0][rd_r[0]], mem_r[1][rd_r[1]]};
    end else begin
      frame_s = last_r;
    end
  end

  assign smp.left_chan_ready  = ready_s[0];
  assign smp.right_chan_ready = ready_s[1];

  // Sample storage; contents are don't-care until counted, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (push_s[ch]) begin
        mem_r[ch][wr_r[ch]] <= data_s[ch];
      end
    end
  end

  // FIFO pointers and occupancy; pops only happen with both channels non-empty.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (reset) begin
        wr_r[ch]  <= {AW{1'b0}};
        rd_r[ch]  <= {AW{1'b0}};
        cnt_r[ch] <= {CW{1'b0}};
      end else begin
        if (push_s[ch]) begin
          wr_r[ch] <= wr_r[ch] + AW'(1);
        end
        if (pop_s) begin
          rd_r[ch] <= rd_r[ch] + AW'(1);
        end
        case ({push_s[ch], pop_s})
          2'b10:   cnt_r[ch] <= cnt_r[ch] + CW'(1);
          2'b01:   cnt_r[ch] <= cnt_r[ch] - CW'(1);
          default: cnt_r[ch] <= cnt_r[ch];
        endcase
      end
    end
  end

  // BCLK divider and frame shifter; serial pins move only on BCLK falling edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r     <= {DW{1'b0}};
      bclk_r    <= 1'b0;
      bit_cnt_r <= 5'd31;
      sh_r      <= 32'd0;
      last_r    <= 32'd0;
      dat_r     <= 1'b0;
      lrck_r    <= 1'b0;
      und_r     <= 1'b0;
    end else begin
      und_r <= start_s && !both_s;
      div_r <= wrap_s ? {DW{1'b0}} : div_r + DW'(1);
      if (wrap_s) begin
        bclk_r <= ~bclk_r;
      end
      if (fall_s) begin
        bit_cnt_r <= next_bit_s;
        dat_r     <= sh_r[31];
        lrck_r    <= (next_bit_s >= 5'd16);
        // Loading at frame start delays L[15] by one BCLK, giving the I2S one-bit offset.
        sh_r      <= start_s ? frame_s : {sh_r[30:0], 1'b0};
      end
      if (pop_s) begin
        last_r <= frame_s;
      end
    end
  end

  assign AUD_BCLK    = bclk_r;
  assign AUD_DACLRCK = lrck_r;
  assign AUD_DACDAT  = dat_r;
  assign underrun    = und_r;
endmodule

// File: tb/tb_audio_i2s_out.sv
// Self-checking bench for audio_i2s_out: a timeline model of the I2S pins and FIFO queues checks
// every cycle, plus a fill table and hand-written frame, underrun and reset sequences.
module tb_audio_i2s_out;
  localparam int DEPTH    = 8;
  localparam int HALF_DIV = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bclk, lrck, dat, und;

  audio_i2s_out_if bus ();

  audio_i2s_out #(.DEPTH(DEPTH), .HALF_DIV(HALF_DIV)) dut (
    .clk(clk), .reset(reset), .smp(bus.slave),
    .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat), .underrun(und)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference: queues per channel, current/previous frame, cycles since reset.
  logic [15:0] ql[$];
  logic [15:0] qr[$];
  logic [31:0] cur_f = 32'd0;
  logic [31:0] prev_f = 32'd0;
  int t = 0;

  typedef struct {
    logic        vl;
    logic [15:0] dl;
    logic        exp_rl;
    logic        exp_rr;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: apply current inputs, advance the reference, compare all outputs.
  task automatic step();
    bit rl, rr, st, both;
    int e, b;
    logic [15:0] lv, rv;
    logic [5:0] exp_v, act_v;
    rl = (ql.size() != DEPTH);
    rr = (qr.size() != DEPTH);
    @(posedge clk);
    #1;
    st = 1'b0;
    both = 1'b0;
    if (reset) begin
      ql.delete();
      qr.delete();
      cur_f = 32'd0;
      prev_f = 32'd0;
      t = 0;
    end else begin
      t++;
      st = (t >= 2 * HALF_DIV) && (((t - 2 * HALF_DIV) % (64 * HALF_DIV)) == 0);
      both = (ql.size() > 0) && (qr.size() > 0);
      if (st) begin
        prev_f = cur_f;
        if (both) begin
          lv = ql.pop_front();
          rv = qr.pop_front();
          cur_f = {lv, rv};
        end
      end
      if (bus.sample_valid_l && rl) ql.push_back(bus.sample_data_l);
      if (bus.sample_valid_r && rr) qr.push_back(bus.sample_data_r);
    end
    e = t / (2 * HALF_DIV);
    exp_v[5] = ((t / HALF_DIV) % 2) == 1;
    if (e == 0) begin
      exp_v[4] = 1'b0;
      exp_v[3] = 1'b0;
    end else begin
      b = (e - 1) % 32;
      exp_v[4] = (b >= 16);
      exp_v[3] = (b == 0) ? prev_f[0] : cur_f[32 - b];
    end
    exp_v[2] = st && !both;
    exp_v[1] = (ql.size() != DEPTH);
    exp_v[0] = (qr.size() != DEPTH);
    act_v = {bclk, lrck, dat, und, bus.left_chan_ready, bus.right_chan_ready};
    chk($sformatf("pins{bclk,lrck,dat,und,rdy_l,rdy_r}@t=%0d", t), {26'd0, act_v}, {26'd0, exp_v});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] cap_d, cap_l, exp_d;
    bus.sample_data_l = 16'd0;
    bus.sample_valid_l = 1'b0;
    bus.sample_data_r = 16'd0;
    bus.sample_valid_r = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tbl[i].vl = (i < 9);
      tbl[i].dl = 16'(16'h1000 + i);
      tbl[i].exp_rl = (i < 7);
      tbl[i].exp_rr = 1'b1;
    end

    // A: one stereo sample, then a left-only frame that must repeat it.
    do_reset();
    cap_d = 32'd0;
    cap_l = 32'd0;
    while (t < 2064) begin
      bus.sample_valid_l = (t == 4) || (t == 600);
      bus.sample_valid_r = (t == 4);
      bus.sample_data_l = (t == 4) ? 16'hA5C3 : 16'h1234;
      bus.sample_data_r = 16'h0F0F;
      step();
      if (t == 16) chk("bclk_first_rise", {31'd0, bclk}, 32'd1);
      if (t == 32) chk("no_underrun_f1", {31'd0, und}, 32'd0);
      if (t == 1056) chk("underrun_left_only", {31'd0, und}, 32'd1);
      if (t >= 48 && t <= 1040 && ((t - 48) % 32) == 0) begin
        cap_d = {cap_d[30:0], dat};
        cap_l = {cap_l[30:0], lrck};
      end
      if (t == 1040) begin
        exp_d = {1'b0, 16'hA5C3, 15'h0787};
        chk("frame1_data", cap_d, exp_d);
        chk("frame1_lrck", cap_l, 32'h0000FFFF);
        cap_d = 32'd0;
      end
      if (t >= 1072 && t <= 2064 && ((t - 1072) % 32) == 0) cap_d = {cap_d[30:0], dat};
    end
    exp_d = {1'b1, 16'hA5C3, 15'h0787};
    chk("frame2_repeat", cap_d, exp_d);
    bus.sample_valid_l = 1'b0;
    bus.sample_valid_r = 1'b0;

    // B: fill left from the table, fill right, then pushes coinciding with frame-start pops.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.sample_valid_l = tbl[i].vl;
      bus.sample_data_l = tbl[i].dl;
      step();
      chk($sformatf("tbl_rdy_l[%0d]", i), {31'd0, bus.left_chan_ready}, {31'd0, tbl[i].exp_rl});
      chk($sformatf("tbl_rdy_r[%0d]", i), {31'd0, bus.right_chan_ready}, {31'd0, tbl[i].exp_rr});
    end
    bus.sample_valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.sample_valid_r = 1'b1;
      bus.sample_data_r = 16'(16'h2000 + i);
      step();
    end
    bus.sample_valid_r = 1'b0;
    while (t < 9300) begin
      bus.sample_valid_l = (t == 31) || (t == 1055);
      bus.sample_data_l = (t == 31) ? 16'hBEEF : 16'hCAFE;
      step();
      if (t == 32) chk("full_push_dropped", {31'd0, bus.left_chan_ready}, 32'd1);
      if (t == 1056) chk("push_pop_at_7", {31'd0, bus.left_chan_ready}, 32'd1);
    end
    bus.sample_valid_l = 1'b0;

    // C: reset at frame bit 10 with a push pending.
    do_reset();
    while (t < 360) begin
      bus.sample_valid_l = (t == 3);
      bus.sample_valid_r = (t == 3);
      bus.sample_data_l = 16'h7E81;
      bus.sample_data_r = 16'h3C3C;
      step();
    end
    bus.sample_valid_l = 1'b1;
    bus.sample_valid_r = 1'b1;
    do_reset();
    bus.sample_valid_l = 1'b0;
    bus.sample_valid_r = 1'b0;
    chk("rst_outputs", {28'd0, bclk, lrck, dat, und}, 32'd0);
    chk("rst_ready", {30'd0, bus.left_chan_ready, bus.right_chan_ready}, 32'd3);
    while (t < 32) begin
      step();
      if (t == 31) chk("rst_no_early_start", {31'd0, und}, 32'd0);
    end
    chk("rst_restart_underrun", {31'd0, und}, 32'd1);

    // D: random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      bus.sample_valid_l = ($urandom_range(0, 99) < 3);
      bus.sample_valid_r = ($urandom_range(0, 99) < 3);
      bus.sample_data_l = 16'($urandom);
      bus.sample_data_r = 16'($urandom);
      reset = ($urandom_range(0, 4999) == 0);
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/audio_i2s_out.md
# audio_i2s_out

Stereo audio output stage that sits directly downstream of the sound-effect playback logic. It accepts 16-bit left/right samples on per-channel valid/ready handshakes and buffers each channel in its own FIFO. It then serialises one stereo frame per I2S period onto the board's audio DAC pins (BCLK, DACLRCK, DACDAT), all from the 50 MHz system clock. It replaces the vendor audio core, and its `left_chan_ready`/`right_chan_ready` outputs drive the playback logic's ready inputs.

## Interface
Clock is `clk`, reset is `reset`: one clock; reset is synchronous and active-high.

Parameters:
- `DEPTH`, 8: entries per channel FIFO. Power of two, ≥ 2.
- `HALF_DIV`, 16: clk cycles per BCLK half-period. BCLK = 50 MHz / 32 = 1.5625 MHz, fs = 48.828 kHz.

Ports:
- `clk`  in  1: 50 MHz system clock.
- `reset`  in  1: synchronous, active-high.
- `sample_data_l`  in  16: left sample, two's complement.
- `sample_valid_l`  in  1: left sample present this cycle.
- `sample_data_r`  in  16: right sample, two's complement.
- `sample_valid_r`  in  1: right sample present this cycle.
- `left_chan_ready`  out  1: left FIFO can accept a sample.
- `right_chan_ready`  out  1: right FIFO can accept a sample.
- `AUD_BCLK`  out  1: I2S bit clock.
- `AUD_DACLRCK`  out  1: word select. 0 = left, 1 = right.
- `AUD_DACDAT`  out  1: serial data, MSB first.
- `underrun`  out  1: one-cycle pulse when a frame starts with either FIFO empty.

## Operation
FIFOs:
- Each channel has its own FIFO, `DEPTH` entries, with a count of 0..DEPTH.
- `*_chan_ready = (count != DEPTH)`. This is combinational from the registered count.
- A push happens when valid && ready. If valid is high while ready is low, the sample is dropped silently.
- A push and a pop in the same cycle leave count unchanged and both operations take effect.
- The left and right FIFOs are independent, so their counts may differ.

Clock generation:
- `div` counts 0..HALF_DIV-1. When it wraps, BCLK toggles.
- A falling-edge event is a wrap while BCLK = 1.
- All serial state changes only on falling-edge events.

Frame sequencer (`bit_cnt`, 0..31):
- `bit_cnt` increments on each falling edge and wraps 31→0. The edge on which it becomes 0 is the frame-start edge.
- At frame start, if both FIFOs are non-empty:
  - pop both FIFOs;
  - latch `{L,R}` into `last`.
- At frame start, if either FIFO is empty:
  - pop neither FIFO, even if the other channel is non-empty;
  - keep `last`, so the output repeats the previous frame;
  - pulse `underrun` high for exactly one clk cycle.
- Shift register `sh[31:0]` behaviour on every falling edge:
  - `AUD_DACDAT <= sh[31]`;
  - `sh <= sh << 1`;
  - on the frame-start edge only, `sh` is instead loaded with the frame value (`{L,R}` after a pop, otherwise `last`).
- Resulting bit order, which gives the I2S one-bit delay:
  - edge 0 carries the previous frame's R[0];
  - edges 1..16 carry L[15..0];
  - edges 17..31 carry R[15..1].
- `AUD_DACLRCK <= (new bit_cnt >= 16)`. It goes high on the same edge that outputs L[0].

Reset (any cycle, including mid-frame or mid-push):
- Outputs: BCLK = 0, DACLRCK = 0, DACDAT = 0, underrun = 0.
- Internal state: `div` = 0, `bit_cnt` = 31, `sh` = 0, `last` = 0, both FIFO counts and pointers = 0.
- Ready outputs read 1 from the first cycle after reset deasserts.
- Any in-flight frame is abandoned without completing.

## Timing
- Taking reset deasserted after cycle 0:
  - BCLK first rises at cycle HALF_DIV;
  - the first falling edge, which is the first frame start, is at cycle 2·HALF_DIV = 32.
- BCLK period is 32 clk cycles. Frame period is 1024 clk cycles.
- A push updates count at the next clock edge, so ready falls one cycle after the push that fills the FIFO.
- Push-to-pin latency with FIFOs empty and the push arriving before the frame-start edge:
  - the sample loads at that frame start;
  - its MSB appears 32 clk cycles later.
- DACDAT and DACLRCK change only in the cycle BCLK falls. They are stable across every BCLK rising edge.

## Test plan
- Reset release with no input:
  - BCLK toggles every 16 cycles, first rising at cycle 16;
  - DACDAT stays 0;
  - `underrun` pulses at cycles 32, 1056, 2080, …
- Push L = 16'hA5C3 and R = 16'h0F0F at cycle 5, then sample DACDAT on BCLK rising edges:
  - the frame from cycle 32 reads 0, then A5C3 MSB first while LRCK = 0, then 0F0F;
  - LRCK rises on the edge carrying L bit 0;
  - no underrun pulse at cycle 32.
- Push 9 left samples back-to-back with no pops:
  - `left_chan_ready` drops after the 8th push;
  - the 9th sample is dropped;
  - `right_chan_ready` stays 1.
- Only the left FIFO holds data at frame start:
  - no pop occurs, left count stays unchanged;
  - `underrun` pulses;
  - the previous frame `{L,R}` is retransmitted bit-for-bit.
- FIFO full and a push coincident with the frame-start pop cycle:
  - ready is 0, so the push is dropped and count becomes 7.
  - Repeat at count 7 with valid high: count stays 7 and both samples are preserved in order.
- Assert reset for 1 cycle at mid-frame bit 10:
  - all outputs reach their reset values the next cycle;
  - FIFOs are empty;
  - the next frame start occurs 32 cycles after release.
